// File: rtl/fp_int_mac_seq_if.sv
// Stream and MAC-lane signal bundle for fp_int_mac_seq.
// The slave modport is the sequencer. The master modport is its environment: the tile buffer, the MAC and the result sink.
interface fp_int_mac_seq_if #(
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int WGT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ACT_WIDTH-1:0] in_act;
    logic [WGT_WIDTH-1:0] in_wgt;

    logic                 mac_valid;
    logic [3:0]           mac_precision;
    logic [ACT_WIDTH-1:0] mac_act;
    logic                 mac_w;
    logic [4:0]           mac_exp_set;
    logic [ACC_WIDTH-1:0] mac_acc;
    logic                 mac_done;
    logic [4:0]           mac_exp;
    logic [ACC_WIDTH-1:0] mac_fixed;

    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           out_exp;
    logic [ACC_WIDTH-1:0] out_fixed;

    modport slave (
        input  in_valid, in_act, in_wgt, mac_done, mac_exp, mac_fixed, out_ready,
        output in_ready, mac_valid, mac_precision, mac_act, mac_w, mac_exp_set,
               mac_acc, out_valid, out_exp, out_fixed
    );

    modport master (
        output in_valid, in_act, in_wgt, mac_done, mac_exp, mac_fixed, out_ready,
        input  in_ready, mac_valid, mac_precision, mac_act, mac_w, mac_exp_set,
               mac_acc, out_valid, out_exp, out_fixed
    );
endinterface

// File: rtl/fp_int_mac_seq.sv
// Sequencer that drives one fp_int_mac lane through a K-element dot product, MSB-first bit-serial weights.
// Optional performance counters are enabled with `define FPMAC_SEQ_PERF_EN.
module fp_int_mac_seq #(
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int WGT_WIDTH = 8,
    parameter int LEN_WIDTH = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start_i,
    input  logic [LEN_WIDTH-1:0] cfg_len_i,
    input  logic [3:0]           cfg_precision_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [31:0]          perf_busy_cycles_o,
    output logic [31:0]          perf_stall_cycles_o,
    fp_int_mac_seq_if.slave      bus
);
    localparam int         TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [4:0] PREC_MAX = 5'(WGT_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_WAIT, S_OUT} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic [3:0]           prec_q, prec_d, bitcnt_q, bitcnt_d, bit_idx;
    logic [ACT_WIDTH-1:0] act_q, act_d;
    logic [WGT_WIDTH-1:0] wgt_q, wgt_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [4:0]           exp_q, exp_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 err_q, err_d;
    logic                 cfg_ok;

    assign cfg_ok  = (cfg_len_i != '0) && (cfg_precision_i != 4'd0) &&
                     ({1'b0, cfg_precision_i} <= PREC_MAX);
    assign bit_idx = prec_q - 4'd1 - bitcnt_q;
    assign cnt_inc = cnt_q + LEN_WIDTH'(1);
    assign busy_o  = (state_q != S_IDLE);
    assign err_o   = err_q;
    assign bus.mac_precision = prec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            prec_q   <= '0;
            bitcnt_q <= '0;
            act_q    <= '0;
            wgt_q    <= '0;
            timer_q  <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            prec_q   <= prec_d;
            bitcnt_q <= bitcnt_d;
            act_q    <= act_d;
            wgt_q    <= wgt_d;
            timer_q  <= timer_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        cnt_d           = cnt_q;
        prec_d          = prec_q;
        bitcnt_d        = bitcnt_q;
        act_d           = act_q;
        wgt_d           = wgt_q;
        timer_d         = timer_q;
        exp_d           = exp_q;
        acc_d           = acc_q;
        err_d           = 1'b0;
        bus.in_ready    = 1'b0;
        bus.mac_valid   = 1'b0;
        bus.mac_act     = '0;
        bus.mac_w       = 1'b0;
        bus.mac_exp_set = '0;
        bus.mac_acc     = '0;
        bus.out_valid   = 1'b0;
        bus.out_exp     = '0;
        bus.out_fixed   = '0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start_i) begin
                    if (cfg_ok) begin
                        len_d   = cfg_len_i;
                        prec_d  = cfg_precision_i;
                        exp_d   = '0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    act_d    = bus.in_act;
                    wgt_d    = bus.in_wgt;
                    bitcnt_d = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Bit precision-1-bitcnt of the weight: MSB of the used field goes first.
                bus.mac_valid   = 1'b1;
                bus.mac_act     = act_q;
                bus.mac_w       = |(wgt_q & (WGT_WIDTH'(1) << bit_idx));
                bus.mac_exp_set = exp_q;
                bus.mac_acc     = acc_q;
                if (bitcnt_q == prec_q - 4'd1) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (bus.mac_done) begin
                    exp_d   = bus.mac_exp;
                    acc_d   = bus.mac_fixed;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? S_OUT : S_LOAD;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                bus.out_exp   = exp_q;
                bus.out_fixed = acc_q;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FPMAC_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;
    logic        stall;

    assign stall = ((state_q == S_LOAD) && !bus.in_valid) ||
                   ((state_q == S_OUT) && !bus.out_ready);

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else if ((state_q == S_IDLE) && cfg_start_i && cfg_ok) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_o && !(&perf_busy_q)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (stall && !(&perf_stall_q)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy_cycles_o  = perf_busy_q;
    assign perf_stall_cycles_o = perf_stall_q;
`else
    assign perf_busy_cycles_o  = '0;
    assign perf_stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_fp_int_mac_seq.sv
// Self-checking bench for fp_int_mac_seq: table-driven dot products plus hand-written corner sequences.
// A MAC stub raises done 2 cycles after the last mac_valid and returns exp_set+1 and acc+0x10.
module tb_fp_int_mac_seq;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic [3:0]  cfg_prec = '0;
    logic        busy, err;
    logic [31:0] perf_busy, perf_stall;

    fp_int_mac_seq_if #(.ACT_WIDTH(16), .ACC_WIDTH(32), .WGT_WIDTH(8)) bus ();

    fp_int_mac_seq #(
        .ACT_WIDTH(16), .ACC_WIDTH(32), .WGT_WIDTH(8), .LEN_WIDTH(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_start_i         (cfg_start),
        .cfg_len_i           (cfg_len),
        .cfg_precision_i     (cfg_prec),
        .busy_o              (busy),
        .err_o               (err),
        .perf_busy_cycles_o  (perf_busy),
        .perf_stall_cycles_o (perf_stall),
        .bus                 (bus)
    );

    always #5 clk = ~clk;

    // MAC stub.
    logic       vprev, d1;
    logic [4:0] st_exp;
    logic [31:0] st_acc;
    logic       stub_en = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vprev  <= 1'b0;
            d1     <= 1'b0;
            st_exp <= '0;
            st_acc <= '0;
        end else begin
            vprev <= bus.mac_valid;
            d1    <= vprev & ~bus.mac_valid;
            if (bus.mac_valid) begin
                st_exp <= bus.mac_exp_set + 5'd1;
                st_acc <= bus.mac_acc + 32'h10;
            end
        end
    end
    assign bus.mac_done  = d1 & stub_en;
    assign bus.mac_exp   = st_exp;
    assign bus.mac_fixed = st_acc;

    // Scoreboard records.
    typedef struct packed {
        logic        w;
        logic [4:0]  exp_set;
        logic [31:0] acc;
        logic [15:0] act;
        logic [3:0]  prec;
    } beat_t;
    typedef struct packed {
        logic [4:0]  exp;
        logic [31:0] fixed;
    } res_t;
    typedef struct {
        int          len;
        logic [3:0]  prec;
        logic [7:0]  wgt [4];
        logic [4:0]  exp_out;
        logic [31:0] fixed_out;
    } vec_t;

    beat_t mac_q[$];
    res_t  res_q[$];
    beat_t mb;
    res_t  rb;
    vec_t  vt [4];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Every MAC beat must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n && bus.mac_valid) begin
            if (mac_q.size() == 0) begin
                check("mac_beat_unexpected", 64'(1), 64'(0));
            end else begin
                mb = mac_q.pop_front();
                check("mac_w",         64'(bus.mac_w),         64'(mb.w));
                check("mac_exp_set",   64'(bus.mac_exp_set),   64'(mb.exp_set));
                check("mac_acc",       64'(bus.mac_acc),       64'(mb.acc));
                check("mac_act",       64'(bus.mac_act),       64'(mb.act));
                check("mac_precision", 64'(bus.mac_precision), 64'(mb.prec));
            end
        end
    end

    // Every result handshake must match the next expected result.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (res_q.size() == 0) begin
                check("out_unexpected", 64'(1), 64'(0));
            end else begin
                rb = res_q.pop_front();
                check("out_exp",   64'(bus.out_exp),   64'(rb.exp));
                check("out_fixed", 64'(bus.out_fixed), 64'(rb.fixed));
                $display("result: exp=%0d fixed=0x%0h", bus.out_exp, bus.out_fixed);
            end
        end
    end

    task automatic do_cfg(input logic [7:0] len, input logic [3:0] prec);
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_len   = len;
        cfg_prec  = prec;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send_elem(input logic [15:0] act, input logic [7:0] wgt,
                             input logic [3:0] prec, input int k);
        beat_t b;
        bit    ok;
        for (int j = 0; j < int'(prec); j++) begin
            int idx;
            idx       = int'(prec) - 1 - j;
            b.w       = wgt[idx];
            b.exp_set = 5'(k);
            b.acc     = 32'(16 * k);
            b.act     = act;
            b.prec    = prec;
            mac_q.push_back(b);
        end
        bus.in_valid = 1'b1;
        bus.in_act   = act;
        bus.in_wgt   = wgt;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("in_accept", 64'(ok), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'(1));
        check("idle_out_valid", 64'(bus.out_valid), 64'(0));
    endtask

    task automatic run_vec(input int i);
        res_t r;
        r.exp   = vt[i].exp_out;
        r.fixed = vt[i].fixed_out;
        res_q.push_back(r);
        $display("vector %0d: len=%0d prec=%0d", i, vt[i].len, vt[i].prec);
        do_cfg(8'(vt[i].len), vt[i].prec);
        for (int k = 0; k < vt[i].len; k++) begin
            send_elem(16'h3C00 + 16'(k), vt[i].wgt[k], vt[i].prec, k);
        end
        wait_idle("vec_done");
        check("vec_mac_q_empty", 64'(mac_q.size()), 64'(0));
        check("vec_res_q_empty", 64'(res_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        logic [7:0] bad_len [3];
        logic [3:0] bad_prec [3];

        vt[0].len = 1; vt[0].prec = 4'd4;
        vt[0].wgt[0] = 8'h0B; vt[0].wgt[1] = 8'h00; vt[0].wgt[2] = 8'h00; vt[0].wgt[3] = 8'h00;
        vt[0].exp_out = 5'd1; vt[0].fixed_out = 32'h10;
        vt[1].len = 3; vt[1].prec = 4'd2;
        vt[1].wgt[0] = 8'h01; vt[1].wgt[1] = 8'h02; vt[1].wgt[2] = 8'h03; vt[1].wgt[3] = 8'h00;
        vt[1].exp_out = 5'd3; vt[1].fixed_out = 32'h30;
        vt[2].len = 2; vt[2].prec = 4'd8;
        vt[2].wgt[0] = 8'hA5; vt[2].wgt[1] = 8'h3C; vt[2].wgt[2] = 8'h00; vt[2].wgt[3] = 8'h00;
        vt[2].exp_out = 5'd2; vt[2].fixed_out = 32'h20;
        vt[3].len = 4; vt[3].prec = 4'd1;
        vt[3].wgt[0] = 8'h01; vt[3].wgt[1] = 8'h00; vt[3].wgt[2] = 8'h01; vt[3].wgt[3] = 8'hFF;
        vt[3].exp_out = 5'd4; vt[3].fixed_out = 32'h40;

        bad_len[0] = 8'd1; bad_prec[0] = 4'd0;
        bad_len[1] = 8'd1; bad_prec[1] = 4'd9;
        bad_len[2] = 8'd0; bad_prec[2] = 4'd4;

        bus.in_valid  = 1'b0;
        bus.in_act    = '0;
        bus.in_wgt    = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy",      64'(busy),              64'(0));
        check("rst_err",       64'(err),               64'(0));
        check("rst_in_ready",  64'(bus.in_ready),      64'(0));
        check("rst_mac_valid", 64'(bus.mac_valid),     64'(0));
        check("rst_mac_prec",  64'(bus.mac_precision), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid),     64'(0));
        check("rst_out_fixed", 64'(bus.out_fixed),     64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_vec(i);
        end

        // Illegal configurations.
        for (int i = 0; i < 3; i++) begin
            $display("illegal cfg: len=%0d prec=%0d", bad_len[i], bad_prec[i]);
            do_cfg(bad_len[i], bad_prec[i]);
            @(negedge clk);
            check("illegal_err",  64'(err),  64'(1));
            check("illegal_busy", 64'(busy), 64'(0));
            @(negedge clk);
            check("illegal_err_pulse", 64'(err),  64'(0));
            check("illegal_busy2",     64'(busy), 64'(0));
        end

        // Backpressure on both streams.
        $display("backpressure: len=1 prec=3");
        rb.exp = 5'd1; rb.fixed = 32'h10;
        res_q.push_back(rb);
        bus.out_ready = 1'b0;
        do_cfg(8'd1, 4'd3);
        repeat (5) begin
            @(negedge clk);
            check("bp_no_mac",   64'(bus.mac_valid), 64'(0));
            check("bp_in_ready", 64'(bus.in_ready),  64'(1));
        end
        @(posedge clk); #1;
        send_elem(16'h3C00, 8'h06, 4'd3, 0);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_out_valid_seen", 64'(ok), 64'(1));
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            check("bp_out_valid_hold", 64'(bus.out_valid), 64'(1));
            check("bp_out_exp_hold",   64'(bus.out_exp),   64'(1));
            check("bp_out_fixed_hold", 64'(bus.out_fixed), 64'(32'h10));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_idle("bp_done");
        check("bp_res_q_empty", 64'(res_q.size()), 64'(0));
`ifdef FPMAC_SEQ_PERF_EN
        check("perf_stall", 64'(perf_stall), 64'(9));
        check("perf_busy",  64'(perf_busy),  64'(16));
`else
        check("perf_stall_tied", 64'(perf_stall), 64'(0));
        check("perf_busy_tied",  64'(perf_busy),  64'(0));
`endif

        // Timeout: the stub never answers.
        $display("timeout: len=1 prec=2");
        stub_en = 1'b0;
        do_cfg(8'd1, 4'd2);
        send_elem(16'h4000, 8'h02, 4'd2, 0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!bus.mac_valid) break;
        end
        n = 0;
        while (!err && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 64'(n),    64'(TIMEOUT));
        check("timeout_busy",   64'(busy), 64'(0));
        @(negedge clk);
        check("timeout_err_pulse", 64'(err), 64'(0));
        stub_en = 1'b1;
        repeat (5) @(negedge clk);
        check("timeout_no_out", 64'(bus.out_valid), 64'(0));
        check("timeout_mac_q",  64'(mac_q.size()),  64'(0));

        // Reset in the middle of element 2 of 3.
        $display("abort: reset during element 2 of 3");
        do_cfg(8'd3, 4'd4);
        send_elem(16'h3C00, 8'h05, 4'd4, 0);
        send_elem(16'h3C01, 8'h0A, 4'd4, 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_mac_valid", 64'(bus.mac_valid), 64'(0));
        check("abort_mac_acc",   64'(bus.mac_acc),   64'(0));
        check("abort_busy",      64'(busy),          64'(0));
        check("abort_in_ready",  64'(bus.in_ready),  64'(0));
        check("abort_out_valid", 64'(bus.out_valid), 64'(0));
        mac_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/fp_int_mac_seq.md
Name: fp_int_mac_seq

Overview:
- Sequencer that drives one fp_int_mac lane through a K-element dot product.
- Accepts (fp16 activation, int weight) pairs over a valid/ready stream and serialises each weight bit-serially, MSB first, for `precision` cycles.
- Waits for the MAC `done` pulse, then feeds the running exponent/fixed-point sum back as the accumulator seed for the next element.
- Emits the final (exp, fixed) result on an output handshake; sits between the tile buffer and the MAC.

Parameters:
- ACT_WIDTH, 16, activation width (fp16).
- ACC_WIDTH, 32, MAC fixed-point accumulator width.
- WGT_WIDTH, 8, max weight word width; legal precision is 1..WGT_WIDTH.
- LEN_WIDTH, 8, width of vector-length config.
- TIMEOUT, 15, max cycles to wait for mac_done per element.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- cfg_start  in  1  pulse; latches cfg_len/cfg_precision when idle
- cfg_len  in  LEN_WIDTH  elements per dot product; 0 is illegal
- cfg_precision  in  4  weight bits per element; 0 or >WGT_WIDTH is illegal
- busy  out  1  high from accepted cfg_start until result handshake completes
- err  out  1  one-cycle pulse on illegal config or timeout
- in_valid  in  1  element valid
- in_ready  out  1  element accept
- in_act  in  ACT_WIDTH  fp16 activation
- in_wgt  in  WGT_WIDTH  weight, low cfg_precision bits used
- mac_valid  out  1  to MAC valid
- mac_precision  out  4  to MAC precision (latched value)
- mac_act  out  ACT_WIDTH  to MAC act
- mac_w  out  1  to MAC serial weight bit
- mac_exp_set  out  5  to MAC exp_set
- mac_acc  out  32  to MAC fixed_point_acc
- mac_done  in  1  from MAC done
- mac_exp  in  5  from MAC exp_out
- mac_fixed  in  ACC_WIDTH  from MAC fixed_point_out
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_exp  out  5  result exponent
- out_fixed  out  ACC_WIDTH  result fixed-point sum

Behaviour:
- Reset (rst low, async): state IDLE; every output 0; latched config, counters and feedback registers cleared.
- IDLE:
  - cfg_start with a legal config latches len and precision, clears the feedback regs (exp 0, acc 0) and element count, raises busy, and moves to LOAD.
  - cfg_start with an illegal config pulses err for 1 cycle and stays in IDLE.
  - cfg_start while busy is ignored.
- LOAD: in_ready=1. On in_valid&in_ready, register act and wgt, clear bitcnt, and go to SHIFT on the next cycle. in_ready is 0 in every other state.
- SHIFT: for exactly `precision` consecutive cycles:
  - mac_valid=1, mac_act=registered act, mac_w=wgt[precision-1-bitcnt], mac_exp_set and mac_acc = feedback regs.
  - After the last bit, mac_valid drops to 0 and the state goes to WAIT.
- WAIT:
  - mac_valid=0 and timer counts.
  - First cycle with mac_done=1: capture mac_exp/mac_fixed into the feedback regs and increment the element count.
  - If count==len go to OUT, else go to LOAD.
  - If the timer reaches TIMEOUT without mac_done: pulse err, drop busy, return to IDLE, and produce no output.
- OUT: out_valid=1 with out_exp/out_fixed held stable until out_ready. On handshake: out_valid 0, busy 0, IDLE. out_ready while out_valid=0 has no effect.
- Latency for one element: LOAD accept, then precision SHIFT cycles, then MAC latency to done, then 1 capture cycle.
- mac_done high on entry to WAIT (a stale level) is accepted; the MAC guarantees done is low while valid is high.
- rst asserted mid-operation aborts immediately. Partial sums are discarded and out_valid is never raised for the aborted vector.
- Feedback registers are only updated in WAIT, so in_valid toggling during SHIFT/WAIT has no effect.

Optional Feature:
- FPMAC_SEQ_PERF_EN: adds output ports perf_busy_cycles (32) and perf_stall_cycles (32).
  - perf_busy_cycles counts cycles with busy=1.
  - perf_stall_cycles counts cycles in LOAD with in_valid=0 plus cycles in OUT with out_ready=0.
  - Both clear on accepted cfg_start and saturate at all-ones.
  - Without the macro the ports exist and are tied to 0.

Test Plan:
- Bench uses a MAC stub that raises done 2 cycles after the last mac_valid and returns exp=exp_set+1, fixed=acc+0x10.
- Single element: cfg_len=1, precision=4, act=0x3C00, wgt=0x0B -> mac_w sequence 1,0,1,1 with mac_valid high exactly 4 cycles; out_valid with out_exp=1, out_fixed=0x10; busy low after handshake.
- Three elements, precision=2, wgts 0x1,0x2,0x3 -> mac_acc presented 0x00,0x10,0x20 and mac_exp_set 0,1,2; result exp=3, fixed=0x30.
- Backpressure: in_valid low 5 cycles in LOAD and out_ready low 4 cycles in OUT -> no mac_valid while waiting; out_exp/out_fixed stable; perf_stall_cycles=9 with FPMAC_SEQ_PERF_EN.
- Illegal config: cfg_precision=0, then cfg_precision=9 with WGT_WIDTH=8, then cfg_len=0 -> err pulses each time; busy stays 0.
- Timeout: stub never raises done -> err pulses TIMEOUT cycles after WAIT entry; state returns to IDLE; out_valid never asserted.
- Reset mid-SHIFT of element 2 of 3 -> all outputs 0 immediately; a new cfg_start/vector afterwards yields a result seeded from acc 0.
